// File: rtl/sev_seg_scan_mux.sv
// sev_seg_scan_mux: time-multiplexed scan driver for NUM_DIGITS seven-segment
// digits that share one set of segment pins. Each digit is lit for DIV_CNT
// clocks. All enables are then low for DEAD_CYCLES clocks before the next
// digit is lit. Inputs are captured once per frame, so a frame never mixes
// old and new values.
// Optional build macro: LEADING_ZERO_BLANK_EN suppresses leading zero digits.
// Digit 0 is never suppressed.
module sev_seg_scan_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int DATA_W      = 4,
    parameter int DIV_CNT     = 15000,
    parameter int DEAD_CYCLES = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_DIGITS*DATA_W-1:0]   digit_data,
    input  logic [NUM_DIGITS-1:0]          digit_mask,
    output logic [NUM_DIGITS-1:0]          seg_en,
    output logic [DATA_W-1:0]              sw,
    output logic [$clog2(NUM_DIGITS)-1:0]  digit_idx,
    output logic                           frame_done
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(DIV_CNT + DEAD_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(DIV_CNT - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic {
        ST_SHOW  = 1'b0,
        ST_BLANK = 1'b1
    } state_t;

    state_t                         state_r, state_s;
    logic [CNT_W-1:0]               cnt_r, cnt_s;
    logic                           leave_show_s, leave_blank_s;
    logic [IDX_W-1:0]               digit_idx_r, next_idx_s;
    logic                           wrap_s;
    logic [NUM_DIGITS*DATA_W-1:0]   shadow_data_r, eff_data_s;
    logic [NUM_DIGITS-1:0]          shadow_mask_r, eff_mask_s;
    logic [DATA_W-1:0]              sw_r, next_val_s;
    logic [NUM_DIGITS-1:0]          seg_en_r, next_en_s;
    logic                           frame_done_r;
`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0]          keep_s;
    logic                           upper_nz_s;
`endif

    // One-hot decode of a digit index.
    function automatic logic [NUM_DIGITS-1:0] onehot_f(input logic [IDX_W-1:0] idx);
        logic [NUM_DIGITS-1:0] vec;
        vec = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                vec[k] = 1'b1;
            end else begin
                vec[k] = 1'b0;
            end
        end
        return vec;
    endfunction

    // Next-state logic: SHOW lasts DIV_CNT cycles and BLANK lasts DEAD_CYCLES cycles.
    always_comb begin
        state_s       = state_r;
        cnt_s         = cnt_r + CNT_ONE;
        leave_show_s  = 1'b0;
        leave_blank_s = 1'b0;
        case (state_r)
            ST_SHOW: begin
                if (cnt_r == SHOW_LAST) begin
                    state_s      = ST_BLANK;
                    cnt_s        = '0;
                    leave_show_s = 1'b1;
                end else begin
                    state_s = ST_SHOW;
                end
            end
            ST_BLANK: begin
                if (cnt_r == BLANK_LAST) begin
                    state_s       = ST_SHOW;
                    cnt_s         = '0;
                    leave_blank_s = 1'b1;
                end else begin
                    state_s = ST_BLANK;
                end
            end
            default: begin
                state_s = ST_BLANK;
                cnt_s   = '0;
            end
        endcase
    end

    // Next-digit datapath: the index advances, and inputs are used directly at a wrap.
    always_comb begin
        if (digit_idx_r == LAST_IDX) begin
            next_idx_s = '0;
        end else begin
            next_idx_s = digit_idx_r + IDX_ONE;
        end
        wrap_s = (next_idx_s == '0);
        if (wrap_s) begin
            eff_data_s = digit_data;
            eff_mask_s = digit_mask;
        end else begin
            eff_data_s = shadow_data_r;
            eff_mask_s = shadow_mask_r;
        end
        next_val_s = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (next_idx_s == IDX_W'(k)) begin
                next_val_s = eff_data_s[k*DATA_W +: DATA_W];
            end else begin
                next_val_s = next_val_s;
            end
        end
        next_en_s = onehot_f(next_idx_s) & eff_mask_s;
`ifdef LEADING_ZERO_BLANK_EN
        // A digit is kept only if it or a more significant digit is nonzero.
        upper_nz_s = 1'b0;
        keep_s     = '1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            upper_nz_s = upper_nz_s | (|eff_data_s[k*DATA_W +: DATA_W]);
            keep_s[k]  = upper_nz_s;
        end
        next_en_s = next_en_s & keep_s;
`endif
    end

    // State, counter, shadow capture and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_BLANK;
            cnt_r         <= '0;
            digit_idx_r   <= LAST_IDX;
            sw_r          <= '0;
            seg_en_r      <= '0;
            frame_done_r  <= 1'b0;
            shadow_data_r <= '0;
            shadow_mask_r <= '0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            frame_done_r <= leave_blank_s & wrap_s;
            if (leave_blank_s) begin
                digit_idx_r <= next_idx_s;
                sw_r        <= next_val_s;
                seg_en_r    <= next_en_s;
                if (wrap_s) begin
                    shadow_data_r <= digit_data;
                    shadow_mask_r <= digit_mask;
                end else begin
                    shadow_data_r <= shadow_data_r;
                    shadow_mask_r <= shadow_mask_r;
                end
            end else if (leave_show_s) begin
                seg_en_r <= '0;
            end else begin
                seg_en_r <= seg_en_r;
            end
        end
    end

    assign seg_en     = seg_en_r;
    assign sw         = sw_r;
    assign digit_idx  = digit_idx_r;
    assign frame_done = frame_done_r;

endmodule
